multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I core. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and enable. Its ALU decoder produces the 3-bit operation code the ALU consumes, and it reads back the ALU's `Zero` flag to resolve `beq`. It sits between the instruction register (op/funct fields in) and the datapath muxes, register file, memory and `alu` (controls out).

---
 rtl/multicycle_controller.sv | 119 +++++++++++
 tb/tb_multicycle_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM and ALU decoder; MCCTRL_ILLEGAL_TRAP_EN adds a sticky ERROR state and IllegalInstr
module multicycle_controller #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] ERROR    = 4'd11;
  localparam logic [3:0] BADOP    = ERROR;
`else
  localparam logic [3:0] BADOP    = FETCH;
`endif

  if (XLEN < 1) begin : g_xlen_invalid
  end

  logic [3:0] state, next;
  logic [1:0] aluop;
  logic [2:0] rtype;
  logic       pcupdate, branch;

  // state register; reset parks the FSM in FETCH immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;

  // next-state sequencing per instruction class
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:                   next = DECODE;
      DECODE:                  next = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                                      op == 7'b0110011 ? EXECUTER :
                                      op == 7'b0010011 ? EXECUTEI :
                                      op == 7'b1100011 ? BEQ :
                                      op == 7'b1101111 ? JAL : BADOP;
      MEMADR:                  next = op == 7'b0000011 ? MEMREAD : MEMWRITE;
      MEMREAD:                 next = MEMWB;
      EXECUTER, EXECUTEI, JAL: next = ALUWB;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      ERROR:                   next = ERROR;
`endif
      default:                 next = FETCH;
    endcase
  end

  // Moore outputs decoded from state alone
  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = 2'b00;
    case (state)
      FETCH:    begin IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pcupdate = 1'b1; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      EXECUTER: begin ALUSrcA = 2'b10; aluop = 2'b10; end
      EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; aluop = 2'b10; end
      ALUWB:    RegWrite = 1'b1;
      BEQ:      begin ALUSrcA = 2'b10; aluop = 2'b01; branch = 1'b1; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pcupdate = 1'b1; end
      default:  ;
    endcase
  end

  // ALU decoder; sub only for R-type with funct7[5] set, never for addi
  always_comb begin
    rtype = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
            funct3 == 3'b010 ? 3'b101 :
            funct3 == 3'b110 ? 3'b011 :
            funct3 == 3'b111 ? 3'b010 : 3'b000;
    ALUControl = aluop == 2'b01 ? 3'b001 : aluop == 2'b10 ? rtype : 3'b000;
  end

  assign ImmSrc  = op == 7'b0100011 ? 2'b01 : op == 7'b1100011 ? 2'b10 : op == 7'b1101111 ? 2'b11 : 2'b00;
  assign PCWrite = pcupdate | (branch & Zero);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  assign IllegalInstr = state == ERROR;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors for the multicycle control FSM
module tb_multicycle_controller;
  logic       clk = 1'b0, reset = 1'b1, Zero = 1'b0, funct7b5 = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [15:0] got;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  logic       IllegalInstr;
`endif
  int tests = 0, fails = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [15:0] exp;
    string       tag;
  } vec_t;
  vec_t v[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111;

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    , .IllegalInstr(IllegalInstr)
`endif
  );

  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite};

  function automatic logic [15:0] e(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb, imm,
                                    input logic [2:0] alu, input logic rw);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (pcw adr mw irw rs sa sb imm alu rw)", tag, got, exp);
    end
  endtask

  task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, input logic [15:0] exp, input string tag);
    v.push_back('{o, f3, f7, z, exp, tag});
  endtask

  initial begin
    add(LW, 3'b010, 1'b0, 1'b1, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "lw fetch");
    add(LW, 3'b010, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "lw decode");
    add(LW, 3'b010, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), "lw memadr");
    add(LW, 3'b010, 1'b0, 1'b1, e(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), "lw memread");
    add(LW, 3'b010, 1'b0, 1'b1, e(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1), "lw memwb");
    add(SW, 3'b010, 1'b0, 1'b1, e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0), "sw fetch");
    add(SW, 3'b010, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0), "sw decode");
    add(SW, 3'b010, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0), "sw memadr");
    add(SW, 3'b010, 1'b0, 1'b1, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0), "sw memwrite");
    add(RT, 3'b000, 1'b1, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "sub fetch");
    add(RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "sub decode");
    add(RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0), "sub executer");
    add(RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "sub aluwb");
    add(IT, 3'b000, 1'b1, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "addi fetch");
    add(IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "addi decode");
    add(IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), "addi executei");
    add(IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "addi aluwb");
    add(RT, 3'b111, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "and fetch");
    add(RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "and decode");
    add(RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0), "and executer");
    add(RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "and aluwb");
    add(RT, 3'b110, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "or fetch");
    add(RT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "or decode");
    add(RT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0), "or executer");
    add(RT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "or aluwb");
    add(IT, 3'b010, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "slti fetch");
    add(IT, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "slti decode");
    add(IT, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0), "slti executei");
    add(IT, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "slti aluwb");
    add(RT, 3'b001, 1'b1, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0), "sll fetch");
    add(RT, 3'b001, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "sll decode");
    add(RT, 3'b001, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0), "sll executer");
    add(RT, 3'b001, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), "sll aluwb");
    add(BQ, 3'b000, 1'b0, 1'b1, e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0), "beq taken fetch");
    add(BQ, 3'b000, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), "beq taken decode");
    add(BQ, 3'b000, 1'b0, 1'b1, e(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0), "beq taken");
    add(BQ, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0), "beq nt fetch");
    add(BQ, 3'b000, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), "beq nt decode");
    add(BQ, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0), "beq not taken");
    add(JL, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0), "jal fetch");
    add(JL, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0), "jal decode");
    add(JL, 3'b000, 1'b0, 1'b1, e(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0), "jal");
    add(JL, 3'b000, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1), "jal aluwb");

    #2 chk("reset state", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    tests++;
    if (IllegalInstr !== 1'b0) begin fails++; $display("FAIL reset illegal: got %b required 0", IllegalInstr); end
`endif
    @(negedge clk);
    reset = 1'b0;
    foreach (v[i]) begin
      op = v[i].op; funct3 = v[i].f3; funct7b5 = v[i].f7; Zero = v[i].z;
      #1 chk(v[i].tag, v[i].exp);
      @(negedge clk);
    end

    op = RT; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre-reset executer", e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
    #1 reset = 1'b1;
    #1 chk("async reset", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    @(negedge clk);
    #1 chk("reset held", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    reset = 1'b0;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    chk("unknown fetch", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    @(negedge clk);
    #1 chk("unknown decode", e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    @(negedge clk);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    repeat (3) begin
      Zero = 1'b1;
      #1 chk("error state", 16'h0000);
      tests++;
      if (IllegalInstr !== 1'b1) begin fails++; $display("FAIL error illegal: got %b required 1", IllegalInstr); end
      @(negedge clk);
    end
    #1 reset = 1'b1;
    #1 chk("error cleared", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    tests++;
    if (IllegalInstr !== 1'b0) begin fails++; $display("FAIL cleared illegal: got %b required 0", IllegalInstr); end
`else
    #1 chk("unknown back to fetch", e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    @(negedge clk);
    #1 chk("unknown redecode", e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
